// File: rtl/monitor_gray.sv
// Gray-code stream monitor: decodes the sampled 5-bit Gray word to binary and flags
// transitions that flip more than one bit or that are not a +1 step.
module monitor_gray #(
    parameter int ANCHO         = 5,
    parameter int ANCHO_ERR     = 4,
    parameter int ANCHO_VUELTAS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [ANCHO-1:0]         entrada_gray,
    output logic [ANCHO-1:0]         salida_bin,
    output logic                     valido,
    output logic                     err_multibit,
    output logic                     err_retroceso,
    output logic                     error,
    output logic [ANCHO_ERR-1:0]     cuenta_errores,
    output logic [ANCHO_VUELTAS-1:0] vueltas
);

    typedef enum logic {INICIO, SEGUIMIENTO} estado_t;

    localparam logic [ANCHO-1:0] UNO = ANCHO'(1);

    function automatic logic [ANCHO-1:0] g2b(input logic [ANCHO-1:0] g);
        logic [ANCHO-1:0] b;
        b[ANCHO-1] = g[ANCHO-1];
        for (int i = ANCHO - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic es_un_bit(input logic [ANCHO-1:0] d);
        return (d != '0) && ((d & (d - UNO)) == '0);
    endfunction

    function automatic logic [ANCHO_ERR-1:0] sat_inc(input logic [ANCHO_ERR-1:0] c);
        return (c == '1) ? c : c + ANCHO_ERR'(1);
    endfunction

    estado_t                  estado, estado_sig;
    logic [ANCHO-1:0]         prev_gray, prev_gray_sig;
    logic [ANCHO-1:0]         salida_bin_sig;
    logic                     valido_sig, multibit_sig, retroceso_sig, error_sig;
    logic [ANCHO_ERR-1:0]     cuenta_sig;
    logic [ANCHO_VUELTAS-1:0] vueltas_sig;
    logic [ANCHO-1:0]         bin_nuevo, bin_prev;

    assign bin_nuevo = g2b(entrada_gray);
    assign bin_prev  = g2b(prev_gray);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= INICIO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        if (enable) begin
            estado_sig = SEGUIMIENTO;
        end
    end

    // Any change reloads prev_gray, so one bad jump yields exactly one error.
    always_comb begin
        prev_gray_sig  = prev_gray;
        salida_bin_sig = salida_bin;
        valido_sig     = valido;
        multibit_sig   = 1'b0;
        retroceso_sig  = 1'b0;
        error_sig      = error;
        cuenta_sig     = cuenta_errores;
        vueltas_sig    = vueltas;
        if (enable) begin
            if (estado == INICIO) begin
                prev_gray_sig  = entrada_gray;
                salida_bin_sig = bin_nuevo;
                valido_sig     = 1'b1;
            end else if (entrada_gray != prev_gray) begin
                prev_gray_sig  = entrada_gray;
                salida_bin_sig = bin_nuevo;
                if (!es_un_bit(entrada_gray ^ prev_gray)) begin
                    multibit_sig = 1'b1;
                end else if (bin_nuevo != bin_prev + UNO) begin
                    retroceso_sig = 1'b1;
                end else if (bin_prev == '1) begin
                    vueltas_sig = vueltas + ANCHO_VUELTAS'(1);
                end
                if (multibit_sig || retroceso_sig) begin
                    error_sig  = 1'b1;
                    cuenta_sig = sat_inc(cuenta_errores);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_gray      <= '0;
            salida_bin     <= '0;
            valido         <= 1'b0;
            err_multibit   <= 1'b0;
            err_retroceso  <= 1'b0;
            error          <= 1'b0;
            cuenta_errores <= '0;
            vueltas        <= '0;
        end else begin
            prev_gray      <= prev_gray_sig;
            salida_bin     <= salida_bin_sig;
            valido         <= valido_sig;
            err_multibit   <= multibit_sig;
            err_retroceso  <= retroceso_sig;
            error          <= error_sig;
            cuenta_errores <= cuenta_sig;
            vueltas        <= vueltas_sig;
        end
    end

endmodule

// File: tb/tb_monitor_gray.sv
// Directed self-checking bench for monitor_gray: reset, clean count with wrap,
// stall/freeze, multibit and backward errors, saturation and mid-run reset.
module tb_monitor_gray;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] entrada_gray;
    logic [4:0] salida_bin;
    logic       valido, err_multibit, err_retroceso, error;
    logic [3:0] cuenta_errores;
    logic [7:0] vueltas;

    int checks = 0;
    int errors = 0;

    monitor_gray dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .entrada_gray   (entrada_gray),
        .salida_bin     (salida_bin),
        .valido         (valido),
        .err_multibit   (err_multibit),
        .err_retroceso  (err_retroceso),
        .error          (error),
        .cuenta_errores (cuenta_errores),
        .vueltas        (vueltas)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick(input logic rst, input logic en, input logic [4:0] g);
        @(negedge clk);
        reset        = rst;
        enable       = en;
        entrada_gray = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] bin, input logic val,
                           input logic mb, input logic rt, input logic er,
                           input logic [3:0] cnt, input logic [7:0] vu);
        chk({tag, ".salida_bin"}, 32'(salida_bin), 32'(bin));
        chk({tag, ".valido"}, 32'(valido), 32'(val));
        chk({tag, ".err_multibit"}, 32'(err_multibit), 32'(mb));
        chk({tag, ".err_retroceso"}, 32'(err_retroceso), 32'(rt));
        chk({tag, ".error"}, 32'(error), 32'(er));
        chk({tag, ".cuenta_errores"}, 32'(cuenta_errores), 32'(cnt));
        chk({tag, ".vueltas"}, 32'(vueltas), 32'(vu));
    endtask

    initial begin
        logic [3:0] cnt;
        reset = 1'b1; enable = 1'b1; entrada_gray = 5'b10101;

        // Reset with random input and enable high: reset wins
        tick(1'b1, 1'b1, 5'($urandom));
        tick(1'b1, 1'b1, 5'($urandom));
        chk_all("reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

        // First sample is unchecked
        tick(1'b0, 1'b1, 5'b00000);
        chk_all("first", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

        // Clean count 1..31 then wrap to 0 and step to 1
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 1'b1, b2g(5'(i)));
            chk("count.salida_bin", 32'(salida_bin), 32'(i));
            chk("count.pulses", 32'({err_multibit, err_retroceso}), 32'd0);
        end
        chk("prewrap.vueltas", 32'(vueltas), 32'd0);
        tick(1'b0, 1'b1, 5'b00000);
        chk_all("wrap", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);
        tick(1'b0, 1'b1, 5'b00001);
        chk_all("after_wrap", 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);

        // Stall on 00011 (binary 2)
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 5'b00011);
            chk_all("stall", 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);
        end

        // Freeze: enable low, input change ignored
        tick(1'b0, 1'b0, 5'b11111);
        chk_all("freeze", 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);
        tick(1'b0, 1'b0, 5'b11111);
        chk_all("freeze2", 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);

        // Reset clears vueltas; restart at 00001 (unchecked)
        tick(1'b1, 1'b0, 5'b00000);
        chk_all("reset2", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        tick(1'b0, 1'b1, 5'b00001);
        chk_all("restart", 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

        // Multibit jump 00001 -> 00010, then valid step 00010 -> 00110
        tick(1'b0, 1'b1, 5'b00010);
        chk_all("multibit", 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 8'd0);
        tick(1'b0, 1'b1, 5'b00110);
        chk_all("valid_after_mb", 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 8'd0);

        // Backward single-bit steps: 4->3, 3->2, 2->1
        tick(1'b0, 1'b1, 5'b00010);
        chk_all("back_4_3", 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 8'd0);
        tick(1'b0, 1'b1, 5'b00011);
        chk_all("back_3_2", 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 8'd0);
        tick(1'b0, 1'b1, 5'b00001);
        chk_all("back_2_1", 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 8'd0);
        tick(1'b0, 1'b0, 5'b00001);
        chk_all("pulse_end", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 8'd0);

        // 20 multibit errors alternating 00111 (bin 5) / 00001 (bin 1)
        cnt = 4'd4;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, (i % 2 == 0) ? 5'b00111 : 5'b00001);
            if (cnt != 4'd15) cnt = cnt + 4'd1;
            chk_all("sat", (i % 2 == 0) ? 5'd5 : 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, cnt, 8'd0);
        end
        chk("sat.final", 32'(cuenta_errores), 32'd15);

        // Reset for one cycle mid-run
        tick(1'b1, 1'b1, 5'b10110);
        chk_all("reset3", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

        // Resume clean sequence
        tick(1'b0, 1'b1, 5'b00000);
        chk_all("resume0", 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        for (int i = 1; i < 6; i++) begin
            tick(1'b0, 1'b1, b2g(5'(i)));
            chk_all("resume", 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/monitor_gray.md
# monitor_gray

Downstream checker/decoder for the 5-bit Gray counter stage. It samples the Gray code the counter drives, converts it to binary, and checks every change for two properties: exactly one bit flips, and the step is +1 modulo 2^ANCHO. It reports bad transitions, keeps a saturating error count, and counts wrap-arounds. The testbench instantiates it next to both the behavioural and the synthesized counters as a self-checking monitor.

## Interface
Parameters:
- ANCHO, 5, Gray/binary word width
- ANCHO_ERR, 4, width of error counter (saturating)
- ANCHO_VUELTAS, 8, width of wrap counter (wrapping)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; wins over every other input
- enable  in  1  1 = sample entrada_gray this cycle; 0 = freeze all state and outputs
- entrada_gray  in  ANCHO  Gray value from the counter stage
- salida_bin  out  ANCHO  registered binary equivalent of last sampled Gray value
- valido  out  1  salida_bin holds a sampled value
- err_multibit  out  1  one-cycle pulse: sampled change flipped ≠1 bit
- err_retroceso  out  1  one-cycle pulse: single-bit change, but not a +1 step
- error  out  1  sticky; set by any error pulse, cleared only by reset
- cuenta_errores  out  ANCHO_ERR  number of bad transitions, saturates at all-ones
- vueltas  out  ANCHO_VUELTAS  number of valid wraps (max → 0), wraps to 0 on overflow

## Operation
- Conversion: b[ANCHO-1]=g[ANCHO-1]; b[i]=b[i+1]^g[i]. Internal register prev_gray holds the last sampled Gray word.
- FSM, two states:
  - INICIO (after reset): on enable=1, load prev_gray=entrada_gray, salida_bin=g2b(entrada_gray), valido=1, go to SEGUIMIENTO. No check on the first sample.
  - SEGUIMIENTO: on enable=1, compare entrada_gray with prev_gray.
    - Equal: hold. No pulse. A stalled counter is legal.
    - Hamming distance ≠1: err_multibit=1.
    - Hamming distance =1 and g2b(new) ≠ g2b(prev)+1 mod 2^ANCHO: err_retroceso=1.
    - Valid step, with prev binary = all-ones and new = 0: vueltas+1.
    - On any change, valid or not, load prev_gray and salida_bin from the new value. This resynchronises the checker, so a single bad jump produces exactly one error.
  - enable=0 in either state: no state change. Pulses are 0.
- An error pulse increments cuenta_errores unless it is already all-ones. It also sets error.
- err_multibit and err_retroceso are mutually exclusive. A wrap increment never coincides with an error.
- Reset values: state INICIO, prev_gray=0, salida_bin=0, valido=0, err_multibit=0, err_retroceso=0, error=0, cuenta_errores=0, vueltas=0.

## Timing
- All outputs are registered. entrada_gray sampled at rising edge n appears on salida_bin, the pulses and the counters after edge n, i.e. 1-cycle latency.
- Error pulses last exactly one cycle and then return to 0. They are 0 in any cycle where enable was 0 at the preceding edge.
- Reset asserted mid-operation: at the next edge every output returns to its reset value and the FSM returns to INICIO. The next enabled sample is unchecked.
- Reset and enable both high: reset wins; nothing is sampled.
- Saturation: cuenta_errores stays at 2^ANCHO_ERR−1. error stays 1.
- vueltas overflow: 2^ANCHO_VUELTAS−1 → 0 on the next wrap.

## Test plan
- Reset: hold reset 2 cycles with random entrada_gray → all outputs 0, valido=0. First enabled sample 5'b00000 → salida_bin=0, valido=1, no pulse.
- Clean count: drive the full Gray sequence 0→31→0→1 with enable=1 → salida_bin follows 0..31,0,1 with 1-cycle lag. vueltas=1, error=0, cuenta_errores=0.
- Stall and freeze:
  - Hold entrada_gray=5'b00011 for 10 cycles → no pulses, salida_bin=2.
  - With enable=0, apply 5'b11111 → outputs unchanged.
- Multibit jump: 5'b00001 → 5'b00010 (two bits flip) → err_multibit single-cycle pulse, error=1, cuenta_errores=1, salida_bin=3. Then a valid next step 5'b00110 → no new error.
- Backward step: 5'b00011 → 5'b00001 → err_retroceso pulse, err_multibit=0, cuenta_errores+1.
- Saturation and reset mid-run:
  - Inject 20 multibit errors → cuenta_errores=15 and held, error=1.
  - Assert reset for 1 cycle → all outputs 0.
  - Resume the clean sequence → no errors.
